// File: rtl/boron_pkg.sv
// Shared BORON definitions: sizes, FSM states, S-box pair and the word-level
// shuffle/rotation tables used by both the encryption and decryption paths.
package boron_pkg;

    localparam int ROUNDS  = 25;
    localparam int BLK_W   = 64;
    localparam int KEY_W   = 80;
    localparam int CTR_W   = 5;
    localparam int KEY_ROT = 13;
    localparam int RC_LSB  = 59;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EXPAND = 2'd1,
        WHITEN = 2'd2,
        ROUND  = 2'd3
    } dec_state_t;

    function automatic logic [3:0] sbox4(input logic [3:0] x);
        case (x)
            4'h0: return 4'hE;
            4'h1: return 4'h4;
            4'h2: return 4'hB;
            4'h3: return 4'h1;
            4'h4: return 4'h7;
            4'h5: return 4'h9;
            4'h6: return 4'hC;
            4'h7: return 4'hA;
            4'h8: return 4'hD;
            4'h9: return 4'h2;
            4'hA: return 4'h0;
            4'hB: return 4'hF;
            4'hC: return 4'h8;
            4'hD: return 4'h5;
            4'hE: return 4'h3;
            4'hF: return 4'h6;
            default: return 4'h0;
        endcase
    endfunction

    function automatic logic [3:0] inv_sbox4(input logic [3:0] x);
        case (x)
            4'h0: return 4'hA;
            4'h1: return 4'h3;
            4'h2: return 4'h9;
            4'h3: return 4'hE;
            4'h4: return 4'h1;
            4'h5: return 4'hD;
            4'h6: return 4'hF;
            4'h7: return 4'h4;
            4'h8: return 4'hC;
            4'h9: return 4'h5;
            4'hA: return 4'h7;
            4'hB: return 4'h2;
            4'hC: return 4'h6;
            4'hD: return 4'h8;
            4'hE: return 4'h0;
            4'hF: return 4'hB;
            default: return 4'h0;
        endcase
    endfunction

    // Forward shuffle: destination nibble j of each 16-bit word takes source nibble nib_src(j).
    function automatic int nib_src(input int j);
        case (j)
            0: return 1;
            1: return 3;
            2: return 0;
            3: return 2;
            default: return 0;
        endcase
    endfunction

    // Forward round permutation rotates 16-bit word w left by rot_amt(w).
    function automatic int rot_amt(input int w);
        case (w)
            0: return 1;
            1: return 4;
            2: return 7;
            3: return 9;
            default: return 0;
        endcase
    endfunction

endpackage

// File: rtl/dec_key_scheduler.sv
// Inverse BORON key-schedule step: undoes enc_key_scheduler for the same round index.
module dec_key_scheduler
    import boron_pkg::*;
(
    input  logic [KEY_W-1:0] key_in,
    input  logic [CTR_W-1:0] round,
    output logic [KEY_W-1:0] key_out
);

    logic [KEY_W-1:0] unmixed;

    // Remove the round constant, undo the S-box, then rotate right
    always_comb begin
        unmixed = key_in;
        unmixed[RC_LSB+CTR_W-1:RC_LSB] = key_in[RC_LSB+CTR_W-1:RC_LSB] ^ round;
        unmixed[3:0] = inv_sbox4(key_in[3:0]);
        key_out = {unmixed[KEY_ROT-1:0], unmixed[KEY_W-1:KEY_ROT]};
    end

endmodule

// File: rtl/enc_key_scheduler.sv
// One forward BORON key-schedule step: rotate left 13, S-box the low nibble,
// fold the round index into bits 63:59.
module enc_key_scheduler
    import boron_pkg::*;
(
    input  logic [KEY_W-1:0] key_in,
    input  logic [CTR_W-1:0] round,
    output logic [KEY_W-1:0] key_out
);

    logic [KEY_W-1:0] rotated;

    // Rotate, substitute and add the round constant
    always_comb begin
        rotated = {key_in[KEY_W-1-KEY_ROT:0], key_in[KEY_W-1:KEY_W-KEY_ROT]};
        key_out = rotated;
        key_out[3:0] = sbox4(rotated[3:0]);
        key_out[RC_LSB+CTR_W-1:RC_LSB] = rotated[RC_LSB+CTR_W-1:RC_LSB] ^ round;
    end

endmodule

// File: rtl/inv_block_shuffle.sv
// Inverse of the per-word nibble shuffle: scatters each nibble back to its source slot.
module inv_block_shuffle
    import boron_pkg::*;
(
    input  logic [BLK_W-1:0] din,
    output logic [BLK_W-1:0] dout
);

    // Forward gathered dest j from nib_src(j); here dest nib_src(j) gets j
    always_comb begin
        dout = '0;
        for (int w = 0; w < 4; w++) begin
            for (int j = 0; j < 4; j++) begin
                dout[w*16 + nib_src(j)*4 +: 4] = din[w*16 + j*4 +: 4];
            end
        end
    end

endmodule

// File: rtl/inv_round_permutation.sv
// Inverse round permutation: rotates each 16-bit word right by its forward amount.
module inv_round_permutation
    import boron_pkg::*;
(
    input  logic [BLK_W-1:0] din,
    output logic [BLK_W-1:0] dout
);

    logic [15:0] word;

    // Per-word right rotation
    always_comb begin
        dout = '0;
        word = '0;
        for (int w = 0; w < 4; w++) begin
            word = din[w*16 +: 16];
            dout[w*16 +: 16] = (word >> rot_amt(w)) | (word << (16 - rot_amt(w)));
        end
    end

endmodule

// File: rtl/inv_sbox_layer.sv
// Applies the inverse 4-bit S-box to all sixteen nibbles of the block.
module inv_sbox_layer
    import boron_pkg::*;
(
    input  logic [BLK_W-1:0] din,
    output logic [BLK_W-1:0] dout
);

    // Nibble-parallel inverse substitution
    always_comb begin
        dout = '0;
        for (int n = 0; n < BLK_W / 4; n++) begin
            dout[n*4 +: 4] = inv_sbox4(din[n*4 +: 4]);
        end
    end

endmodule

// File: rtl/inv_xor_operation.sv
// Inverse of the word-mixing XOR layer (forward: y0=x0^x1, y1=x1^x2^x3,
// y2=x2^x3, y3=x3^x0^x1).
module inv_xor_operation
    import boron_pkg::*;
(
    input  logic [BLK_W-1:0] din,
    output logic [BLK_W-1:0] dout
);

    logic [15:0] x0, x1, x2, x3;

    // y1^y2 recovers x1 and y3^y0 recovers x3; the rest follow
    always_comb begin
        x1 = din[31:16] ^ din[47:32];
        x3 = din[63:48] ^ din[15:0];
        x0 = din[15:0] ^ x1;
        x2 = din[47:32] ^ x3;
        dout = {x3, x2, x1, x0};
    end

endmodule

// File: rtl/boron_decryption.sv
// Iterative BORON decryptor: expands the key forward to K25, whitens, then runs
// 25 inverse rounds while stepping the key schedule backwards.
module boron_decryption
    import boron_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic [BLK_W-1:0] cipher_text,
    input  logic [KEY_W-1:0] master_key,
    input  logic             dec_start,
    output logic [BLK_W-1:0] plain_text,
    output logic             dec_done,
    output logic             busy
);

    localparam logic [CTR_W-1:0] LAST_ROUND = CTR_W'(ROUNDS - 1);

    dec_state_t       state, state_next;
    logic [CTR_W-1:0] ctr, ctr_next;
    logic [KEY_W-1:0] key, key_next, key_fwd, key_prev;
    logic [BLK_W-1:0] blk, blk_next, pt_next;
    logic [BLK_W-1:0] after_xor, after_rp, after_bs, after_sbox, round_out;
    logic             done_next, busy_next;

    enc_key_scheduler u_enc_ks (.key_in(key), .round(ctr), .key_out(key_fwd));
    dec_key_scheduler u_dec_ks (.key_in(key), .round(ctr), .key_out(key_prev));

    inv_xor_operation     u_inv_xor (.din(blk),       .dout(after_xor));
    inv_round_permutation u_inv_rp  (.din(after_xor), .dout(after_rp));
    inv_block_shuffle     u_inv_bs  (.din(after_rp),  .dout(after_bs));
    inv_sbox_layer        u_inv_sb  (.din(after_bs),  .dout(after_sbox));

    assign round_out = after_sbox ^ key_prev[BLK_W-1:0];

    // State and datapath registers; blk holds the ciphertext until WHITEN
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            ctr        <= '0;
            key        <= '0;
            blk        <= '0;
            plain_text <= '0;
            dec_done   <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state      <= state_next;
            ctr        <= ctr_next;
            key        <= key_next;
            blk        <= blk_next;
            plain_text <= pt_next;
            dec_done   <= done_next;
            busy       <= busy_next;
        end
    end

    // Next-state and next-register logic
    always_comb begin
        state_next = state;
        ctr_next   = ctr;
        key_next   = key;
        blk_next   = blk;
        pt_next    = plain_text;
        done_next  = 1'b0;
        busy_next  = busy;
        case (state)
            IDLE: begin
                if (dec_start) begin
                    blk_next   = cipher_text;
                    key_next   = master_key;
                    ctr_next   = '0;
                    busy_next  = 1'b1;
                    state_next = EXPAND;
                end else begin
                    state_next = IDLE;
                end
            end
            EXPAND: begin
                key_next = key_fwd;
                if (ctr == LAST_ROUND) begin
                    state_next = WHITEN;
                end else begin
                    ctr_next = ctr + 5'd1;
                end
            end
            WHITEN: begin
                blk_next   = blk ^ key[BLK_W-1:0];
                ctr_next   = LAST_ROUND;
                state_next = ROUND;
            end
            ROUND: begin
                blk_next = round_out;
                key_next = key_prev;
                if (ctr == 5'd0) begin
                    pt_next    = round_out;
                    done_next  = 1'b1;
                    busy_next  = 1'b0;
                    state_next = IDLE;
                end else begin
                    ctr_next = ctr - 5'd1;
                end
            end
            default: begin
                state_next = IDLE;
                busy_next  = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_boron_decryption.sv
// Self-checking bench: random (P,K) are encrypted by a forward reference model
// and the DUT must return P with the specified latency and handshake timing.
module tb_boron_decryption;

    logic        clk = 1'b0;
    logic        reset;
    logic [63:0] cipher_text;
    logic [79:0] master_key;
    logic        dec_start;
    logic [63:0] plain_text;
    logic        dec_done;
    logic        busy;

    always #5 clk = ~clk;

    boron_decryption dut (
        .clk(clk), .reset(reset), .cipher_text(cipher_text), .master_key(master_key),
        .dec_start(dec_start), .plain_text(plain_text), .dec_done(dec_done), .busy(busy)
    );

    logic [79:0] ks_k, ks_e, ks_d;
    logic [4:0]  ks_i;
    enc_key_scheduler u_ek (.key_in(ks_k), .round(ks_i), .key_out(ks_e));
    dec_key_scheduler u_dk (.key_in(ks_e), .round(ks_i), .key_out(ks_d));

    int checks = 0;
    int errors = 0;
    int sb_tab  [16] = '{14, 4, 11, 1, 7, 9, 12, 10, 13, 2, 0, 15, 8, 5, 3, 6};
    int src_tab [4]  = '{1, 3, 0, 2};
    int rot_tab [4]  = '{1, 4, 7, 9};

    task automatic chk(input string tag, input logic [79:0] got, input logic [79:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [79:0] ks_model(input logic [79:0] k, input int i);
        logic [79:0] r;
        r = (k << 13) | (k >> 67);
        r[3:0] = 4'(sb_tab[r[3:0]]);
        r[63:59] = r[63:59] ^ 5'(i);
        return r;
    endfunction

    function automatic logic [63:0] golden_enc(input logic [63:0] p, input logic [79:0] k);
        logic [79:0] kk;
        logic [63:0] x;
        logic [15:0] w [4];
        logic [15:0] t [4];
        kk = k;
        x  = p;
        for (int r = 0; r < 25; r++) begin
            x = x ^ kk[63:0];
            for (int n = 0; n < 16; n++) x[n*4 +: 4] = 4'(sb_tab[x[n*4 +: 4]]);
            for (int q = 0; q < 4; q++) begin
                w[q] = x[q*16 +: 16];
                t[q] = 16'h0;
                for (int j = 0; j < 4; j++) t[q][j*4 +: 4] = w[q][src_tab[j]*4 +: 4];
                t[q] = (t[q] << rot_tab[q]) | (t[q] >> (16 - rot_tab[q]));
            end
            x[15:0]  = t[0] ^ t[1];
            x[31:16] = t[1] ^ t[2] ^ t[3];
            x[47:32] = t[2] ^ t[3];
            x[63:48] = t[3] ^ t[0] ^ t[1];
            kk = ks_model(kk, r);
        end
        return x ^ kk[63:0];
    endfunction

    function automatic logic [79:0] rand_key();
        return {16'($urandom()), $urandom(), $urandom()};
    endfunction

    // Called at #1 after an edge with the DUT idle; returns at #1 after the accept edge T.
    task automatic launch(input logic [63:0] ct, input logic [79:0] key);
        cipher_text = ct;
        master_key  = key;
        dec_start   = 1'b1;
        @(posedge clk); #1;
        dec_start   = 1'b0;
        cipher_text = {$urandom(), $urandom()};
        master_key  = rand_key();
    endtask

    // n = index of the edge (relative to T) that samples the values currently visible.
    task automatic wait_done(output int n, output int busy_bad, output int pt_changes);
        logic [63:0] pt0;
        pt0 = plain_text;
        n = 1;
        busy_bad = 0;
        pt_changes = 0;
        while (dec_done !== 1'b1 && n < 70) begin
            if (busy !== 1'b1) busy_bad++;
            if (plain_text !== pt0) pt_changes++;
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic run_and_check(input string tag, input logic [63:0] pt, input logic [79:0] key);
        int n, bb, pc;
        launch(golden_enc(pt, key), key);
        wait_done(n, bb, pc);
        chk({tag, "_latency"}, 80'(n), 80'(52));
        chk({tag, "_pt"}, 80'(plain_text), 80'(pt));
    endtask

    initial begin
        int n, bb, pc, dones, first_n;
        logic [63:0] pa, pb, got;
        logic [79:0] ka, kb;

        reset = 1'b1; dec_start = 1'b0; cipher_text = 64'h0; master_key = 80'h0;
        ks_k = 80'h0; ks_i = 5'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy", 80'(busy), 80'(0));
        chk("reset_done", 80'(dec_done), 80'(0));
        chk("reset_pt", 80'(plain_text), 80'(0));
        reset = 1'b0;

        for (int i = 0; i < 25; i++) begin
            ks_k = rand_key();
            ks_i = 5'(i);
            #1;
            chk("ks_inverse", ks_d, ks_k);
            chk("ks_forward", ks_e, ks_model(ks_k, i));
        end
        @(posedge clk); #1;

        // Known answer with full handshake timing
        launch(golden_enc(64'h0, 80'h0), 80'h0);
        wait_done(n, bb, pc);
        chk("kat_latency", 80'(n), 80'(52));
        chk("kat_busy_window", 80'(bb), 80'(0));
        chk("kat_pt", 80'(plain_text), 80'(0));
        chk("kat_busy_at_done", 80'(busy), 80'(0));
        @(posedge clk); #1;
        chk("kat_done_one_cycle", 80'(dec_done), 80'(0));

        run_and_check("rt_fixed", 64'h0123_4567_89AB_CDEF, 80'hFFFF_FFFF_FFFF_FFFF_FFFF);

        // Back-to-back: second start in the dec_done cycle
        pa = {$urandom(), $urandom()}; ka = rand_key();
        pb = {$urandom(), $urandom()}; kb = rand_key();
        run_and_check("b2b_first", pa, ka);
        launch(golden_enc(pb, kb), kb);
        wait_done(n, bb, pc);
        chk("b2b_latency", 80'(n), 80'(52));
        chk("b2b_pt_held", 80'(pc), 80'(0));
        chk("b2b_second_pt", 80'(plain_text), 80'(pb));

        // Starts while busy are ignored
        pa = {$urandom(), $urandom()}; ka = rand_key();
        launch(golden_enc(pa, ka), ka);
        n = 1; dones = 0; first_n = 0; got = 64'h0;
        while (n < 120) begin
            if (dec_done === 1'b1) begin
                dones++;
                if (first_n == 0) first_n = n;
                got = plain_text;
            end
            if (n == 9 || n == 39) begin
                cipher_text = {$urandom(), $urandom()};
                dec_start = 1'b1;
            end else begin
                dec_start = 1'b0;
            end
            @(posedge clk); #1;
            n++;
        end
        dec_start = 1'b0;
        chk("ignore_done_count", 80'(dones), 80'(1));
        chk("ignore_latency", 80'(first_n), 80'(52));
        chk("ignore_pt", 80'(got), 80'(pa));

        // Reset sampled at T+30 aborts the operation
        launch(golden_enc({$urandom(), $urandom()}, ka), ka);
        n = 1;
        while (n < 30) begin
            @(posedge clk); #1;
            n++;
        end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("abort_busy", 80'(busy), 80'(0));
        chk("abort_done", 80'(dec_done), 80'(0));
        chk("abort_pt", 80'(plain_text), 80'(0));
        dones = 0;
        repeat (60) begin
            if (dec_done === 1'b1) dones++;
            @(posedge clk); #1;
        end
        chk("abort_no_done", 80'(dones), 80'(0));
        run_and_check("after_abort", {$urandom(), $urandom()}, rand_key());

        for (int i = 0; i < 1000; i++) begin
            run_and_check("rt_random", {$urandom(), $urandom()}, rand_key());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
